// File: rtl/line_xfer_sequencer.sv
// rtl/line_xfer_sequencer.sv - expands one cache-controller request into a 4-word memory line transfer
// Writeback, fill, or evict (writeback then fill), with bank-busy/stall pacing and read-latency tracking.
module line_xfer_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_fill,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic [2:0]        cache_offset,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_wr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic [3:0]        mem_busy,
  input  logic              mem_err
);

  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic                   chain_q, chain_d;
  logic                   err_q, err_d;
  logic [LINE_W-1:0]      wb_line_q, wb_line_d;
  logic [LINE_W-1:0]      fill_line_q, fill_line_d;
  logic [RD_LAT-1:0]      pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][1:0] pipe_k_q, pipe_k_d;

  logic       can_issue;
  logic       push;
  logic       pend;
  logic       out_vld;
  logic [1:0] out_k;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{fill_addr[2:0], wb_addr[2:0]};

  // Word k always targets bank k, since mem_addr[2:1] is the word index.
  assign can_issue = !mem_stall && !mem_busy[k_q];
  assign out_vld   = pipe_vld_q[RD_LAT-1];
  assign out_k     = pipe_k_q[RD_LAT-1];

  // Read-return pipeline: shifts every cycle so latency is fixed regardless of stalls.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_k_d      = '0;
    pipe_vld_d[0] = push;
    pipe_k_d[0]   = k_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_k_d[i]   = pipe_k_q[i-1];
    end
    // Only the output stage may still hold data when the last return is written this cycle.
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pend = pend | pipe_vld_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    chain_d      = chain_q;
    err_d        = err_q;
    wb_line_d    = wb_line_q;
    fill_line_d  = fill_line_q;
    push         = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    cache_wr     = out_vld;
    cache_offset = out_vld ? {out_k, 1'b0} : 3'd0;
    cache_wdata  = out_vld ? mem_rdata : '0;

    if (state_q != S_IDLE && mem_err) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_wb || req_fill) begin
          wb_line_d   = wb_addr[ADDR_W-1:3];
          fill_line_d = fill_addr[ADDR_W-1:3];
          chain_d     = req_wb && req_fill;
          err_d       = 1'b0;
          k_d         = 2'd0;
          state_d     = req_wb ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_addr     = {wb_line_q, k_q, 1'b0};
        cache_offset = {k_q, 1'b0};
        mem_wdata    = cache_rdata;
        if (can_issue) begin
          mem_wr = 1'b1;
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = chain_q ? S_FILL : S_DONE;
            chain_d = 1'b0;
          end
        end
      end
      S_FILL: begin
        mem_addr = {fill_line_q, k_q, 1'b0};
        if (can_issue) begin
          mem_rd = 1'b1;
          push   = 1'b1;
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!pend) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      chain_q     <= 1'b0;
      err_q       <= 1'b0;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      pipe_vld_q  <= '0;
      pipe_k_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      chain_q     <= chain_d;
      err_q       <= err_d;
      wb_line_q   <= wb_line_d;
      fill_line_q <= fill_line_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_k_q    <= pipe_k_d;
    end
  end

endmodule

// File: doc/line_xfer_sequencer.md
Name: line_xfer_sequencer

Overview:
- Sits directly downstream of the direct-mapped cache controller, between it and the four-banked main memory.
- Turns one controller request into the 4-word line transfer the memory needs:
  - writeback: 4 word writes from the cache to memory;
  - fill: 4 word reads from memory into the cache;
  - evict: writeback followed by fill.
- Handles bank-busy and stall pacing, and tracks read latency.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- RD_LAT, 2, cycles from the mem_rd issue cycle to the cycle mem_rdata is valid (range 1-4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_fill  in  1  start a line fill (sampled only when idle)
- req_wb  in  1  start a line writeback (sampled only when idle)
- fill_addr  in  ADDR_W  fill line address; bits [2:0] ignored
- wb_addr  in  ADDR_W  writeback line address; bits [2:0] ignored
- cache_rdata  in  DATA_W  cache word at cache_offset, combinational same cycle
- cache_offset  out  3  word byte-offset into the cache line: {k,1'b0}
- cache_wdata  out  DATA_W  fill data to the cache
- cache_wr  out  1  write cache_wdata at cache_offset
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  memory error seen during the transfer; valid with done
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_busy  in  4  per-bank busy; bank = addr[2:1]
- mem_err  in  1  memory error

Behaviour:
- Reset (async):
  - state IDLE; word counter 0; read pipeline cleared.
  - All outputs 0, including mem_addr, cache_offset, cache_wdata, err.
  - Reset mid-transfer abandons the transfer; no done is produced.
- States: IDLE, WB, FILL, DRAIN, DONE.
- IDLE:
  - req_wb=1 -> latch both addresses; go to WB. If req_fill was also 1, set the chain flag.
  - req_fill=1 only -> go to FILL.
  - Clear sticky err on accept.
  - busy=0 only in IDLE.
- Word issue (WB and FILL):
  - Word k runs 0..3, strictly in order.
  - Word k issues when !mem_stall && !mem_busy[k]. Otherwise hold k and drive no strobe.
  - mem_addr = {line[ADDR_W-1:3], k[1:0], 1'b0}.
  - At most one strobe per cycle.
- WB:
  - cache_offset = {k,0}; mem_wdata = cache_rdata; mem_wr=1 on issue.
  - After the k=3 issue: go to FILL if chain, else DONE.
- FILL:
  - mem_rd=1 on issue.
  - Push {valid, k} into an RD_LAT-deep shift pipeline. The pipeline advances every cycle regardless of stalls.
  - Pipeline output valid -> cache_wr=1, cache_offset={k_out,0}, cache_wdata=mem_rdata.
  - After the k=3 issue -> DRAIN.
- DRAIN:
  - Wait until the pipeline is empty (the last cache_wr has occurred), then go to DONE.
- DONE:
  - done=1 for one cycle, busy=1, err=sticky value; then IDLE.
- Requests arriving while busy are ignored; they are not queued.
- cache_wr and done never share a cycle.
- Sticky err is set by mem_err in any non-IDLE state.
- Latency with no stalls and banks free (cycle 0 = accept edge):
  - fill: issues cycles 1-4, cache_wr cycles 1+RD_LAT..4+RD_LAT, done at 5+RD_LAT;
  - writeback: issues 1-4, done at 5.

Test Plan:
- Bench memory model: a bank is busy for the 3 cycles after its access; RD_LAT=2.
- Fill, fill_addr=0x1234, banks idle:
  - mem_rd at cycles 1-4 to 0x1230/32/34/36;
  - cache_wr at cycles 3-6, offsets 0,2,4,6, with data matching the model;
  - done at cycle 7, err=0.
- Writeback, wb_addr=0xABC8:
  - mem_wr cycles 1-4 to 0xABC8/CA/CC/CE, mem_wdata = cache_rdata at offsets 0,2,4,6;
  - done cycle 5; no cache_wr.
- Evict, req_wb & req_fill in the same cycle, wb 0x0040, fill 0x0080:
  - writes cycles 1-4;
  - reads wait on bank 0 busy until cycle 5, then reads cycles 5-8;
  - cache_wr 7-10; single done at 11.
- Stall:
  - mem_stall=1 during cycles 2-3 of a fill -> word 1 issues at cycle 4, words 2-3 at 5-6;
  - word 0 still writes the cache at cycle 3; done at 9.
- Error and ignore:
  - mem_err pulse at cycle 2 -> err=1 with done.
  - A req_fill asserted while busy is ignored.
  - The next accept clears err.
- Reset mid-fill at cycle 3:
  - all outputs 0 immediately; no done;
  - a new req_fill afterwards completes normally.
